// File: rtl/mul_result_pack_if.sv
// Handshake and data bundle between the multiplier exception stage, the result packer
// and the downstream consumer.
interface mul_result_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_z;
  logic [7:0]  exp_z;
  logic [22:0] mant_z;
  logic        invalid_flag;
  logic        overflow_flag;
  logic        initial_zero_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, sign_z, exp_z, mant_z, invalid_flag, overflow_flag, initial_zero_flag,
    output out_ready,
    input  in_ready, out_valid, result, out_flags
  );

  modport slave (
    input  in_valid, sign_z, exp_z, mant_z, invalid_flag, overflow_flag, initial_zero_flag,
    input  out_ready,
    output in_ready, out_valid, result, out_flags
  );
endinterface

// File: rtl/mul_result_pack.sv
// Packs a single-precision product into an IEEE-754 word behind a two-entry skid buffer.
// Optional sticky exception status is enabled by defining STICKY_FLAGS_EN.
module mul_result_pack #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef STICKY_FLAGS_EN
  input  logic                  flag_clr,
  output logic [2:0]            status,
`endif
  mul_result_pack_if.slave      bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  logic [31:0] o_word_q, s_word_q;
  logic [2:0]  o_flags_q, s_flags_q;
  logic        in_ready_q, out_valid_q;
  logic        accept, drain;
  logic [31:0] packed_word;
  logic [2:0]  in_flags;

  assign in_flags = {bus.invalid_flag, bus.overflow_flag, bus.initial_zero_flag};
  assign accept   = bus.in_valid & in_ready_q;
  assign drain    = out_valid_q & bus.out_ready;

  always_comb begin
    packed_word = {bus.sign_z, bus.exp_z, bus.mant_z};
    if (bus.invalid_flag) begin
      packed_word = QNAN;
    end else if (bus.overflow_flag) begin
      packed_word = {bus.sign_z, 8'hFF, 23'h0};
    end else if (bus.initial_zero_flag) begin
      packed_word = {bus.sign_z, 31'h0};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !drain)      state_d = StTwo;
        else if (!accept && drain) state_d = StEmpty;
      end
      StTwo:   if (drain) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // in_ready/out_valid are registered from the next state so out_ready never reaches in_ready
  // combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      o_word_q    <= 32'h0;
      o_flags_q   <= 3'b0;
      s_word_q    <= 32'h0;
      s_flags_q   <= 3'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StTwo);
      out_valid_q <= (state_d != StEmpty);
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            o_word_q  <= packed_word;
            o_flags_q <= in_flags;
          end
        end
        StOne: begin
          if (accept && drain) begin
            o_word_q  <= packed_word;
            o_flags_q <= in_flags;
          end else if (accept) begin
            s_word_q  <= packed_word;
            s_flags_q <= in_flags;
          end
        end
        StTwo: begin
          if (drain) begin
            o_word_q  <= s_word_q;
            o_flags_q <= s_flags_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = o_word_q;
  assign bus.out_flags = o_flags_q;

`ifdef STICKY_FLAGS_EN
  logic [2:0] status_q;
  logic [2:0] status_set;

  assign status_set = accept ? in_flags : 3'b0;

  // Set wins over clear: a clear in the same cycle as an acceptance keeps that word's flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= 3'b0;
    end else if (flag_clr) begin
      status_q <= status_set;
    end else begin
      status_q <= status_q | status_set;
    end
  end

  assign status = status_q;
`endif

endmodule

// File: tb/tb_mul_result_pack.sv
// Directed self-checking bench for mul_result_pack; define STICKY_FLAGS_EN to also cover
// the sticky status port.
module tb_mul_result_pack;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_result_pack_if bus ();

`ifdef STICKY_FLAGS_EN
  logic       flag_clr;
  logic [2:0] status;
`endif

  mul_result_pack dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef STICKY_FLAGS_EN
    .flag_clr (flag_clr),
    .status   (status),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic inv, input logic ovf, input logic zro);
    bus.in_valid          = 1'b1;
    bus.sign_z            = s;
    bus.exp_z             = e;
    bus.mant_z            = m;
    bus.invalid_flag      = inv;
    bus.overflow_flag     = ovf;
    bus.initial_zero_flag = zro;
  endtask

  // Single word with out_ready high: result appears one cycle later, then drains.
  task automatic send_one(input string tag, input logic s, input logic [7:0] e,
                          input logic [22:0] m, input logic inv, input logic ovf,
                          input logic zro, input logic [31:0] exp_res,
                          input logic [2:0] exp_flags);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(s, e, m, inv, ovf, zro);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_flags"}, {29'h0, bus.out_flags}, {29'h0, exp_flags});
    @(negedge clk);
    check({tag, "_drained"}, {31'h0, bus.out_valid}, 32'h0);
  endtask

  logic [31:0] words [100];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h0, 23'h0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
`ifdef STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {29'h0, bus.out_flags}, 32'h0);
`ifdef STICKY_FLAGS_EN
    check("rst_status", {29'h0, status}, 32'h0);
`endif
    rst_n = 1'b1;

    send_one("normal", 1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 3'b000);
    send_one("inv_ovf", 1'b1, 8'h12, 23'h1234, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b110);
    send_one("ovf", 1'b1, 8'h12, 23'h1234, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b010);
    send_one("zero", 1'b1, 8'h12, 23'h1234, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b001);
    send_one("neg_plain", 1'b1, 8'h7F, 23'h000001, 1'b0, 1'b0, 1'b0, 32'hBF80_0001, 3'b000);

    // Backpressure: A, B fill O and S; C must be held off until a drain.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h81, 23'h0, 1'b0, 1'b0, 1'b0);            // A = 4080_0000
    @(negedge clk);
    check("bp_ready_after_a", {31'h0, bus.in_ready}, 32'h1);
    drive(1'b0, 8'h82, 23'h0, 1'b0, 1'b0, 1'b0);            // B = 4100_0000
    @(negedge clk);
    check("bp_ready_low", {31'h0, bus.in_ready}, 32'h0);
    check("bp_a_head", bus.result, 32'h4080_0000);
    drive(1'b0, 8'h83, 23'h0, 1'b0, 1'b0, 1'b0);            // C = 4180_0000
    @(negedge clk);
    check("bp_ready_held", {31'h0, bus.in_ready}, 32'h0);
    check("bp_a_stable", bus.result, 32'h4080_0000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_b", bus.result, 32'h4100_0000);
    check("bp_ready_back", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_c", bus.result, 32'h4180_0000);
    check("bp_c_valid", {31'h0, bus.out_valid}, 32'h1);
    @(negedge clk);
    check("bp_empty", {31'h0, bus.out_valid}, 32'h0);

    // Streaming with random plain words.
    for (int i = 0; i < 100; i++) begin
      words[i] = $urandom;
      @(negedge clk);
      if (i > 0) begin
        check("stream_result", bus.result, words[i-1]);
        check("stream_ready", {31'h0, bus.in_ready}, 32'h1);
      end
      drive(words[i][31], words[i][30:23], words[i][22:0], 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("stream_last", bus.result, words[99]);
    @(negedge clk);
    check("stream_empty", {31'h0, bus.out_valid}, 32'h0);

    // Reset while both registers are full.
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h90, 23'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h91, 23'h66, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("two_ready_low", {31'h0, bus.in_ready}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("mid_rst_ready", {31'h0, bus.in_ready}, 32'h1);
    check("mid_rst_result", bus.result, 32'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_word", {31'h0, bus.out_valid}, 32'h0);
    end

`ifdef STICKY_FLAGS_EN
    drive(1'b0, 8'h10, 23'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h10, 23'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("sticky_or", {29'h0, status}, 32'h3);
    flag_clr = 1'b1;
    @(negedge clk);
    check("sticky_clr", {29'h0, status}, 32'h0);
    drive(1'b0, 8'h10, 23'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flag_clr = 1'b0;
    check("sticky_set_wins", {29'h0, status}, 32'h4);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
